// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the parametrised UART receiver
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam logic [3:0] SAMPLE_A = 4'd7;
    localparam logic [3:0] SAMPLE_B = 4'd8;
    localparam logic [3:0] SAMPLE_C = 4'd9;
    localparam logic [3:0] BIT_END  = 4'd15;

    // FIFO word layout: {brk, ferr, perr, data[DATA_BITS-1:0]}
    localparam int WORD_DATA_LSB = 0;

    function automatic int word_perr_bit(input int data_bits);
        return data_bits;
    endfunction

    function automatic int word_ferr_bit(input int data_bits);
        return data_bits + 1;
    endfunction

    function automatic int word_brk_bit(input int data_bits);
        return data_bits + 2;
    endfunction

    function automatic int word_width(input int data_bits);
        return data_bits + 3;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - generic synchronous first-word-fall-through FIFO
module uart_rx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    // A pop frees the slot first, so a push into a full FIFO still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - 16x-oversampled UART receiver with configurable frame format and FWFT FIFO
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int LSB_FIRST   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk16x,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          rd_en,
    input  logic                          clr_overrun,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          dout_valid,
    output logic                          dout_perr,
    output logic                          dout_ferr,
    output logic                          dout_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          busy
);

    localparam int WORD_W   = word_width(DATA_BITS);
    localparam int PERR_BIT = word_perr_bit(DATA_BITS);
    localparam int FERR_BIT = word_ferr_bit(DATA_BITS);
    localparam int BRK_BIT  = word_brk_bit(DATA_BITS);
    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    rx_state_e state;
    rx_state_e next_state;

    logic                 rxd_m;
    logic                 rxd_s;
    logic                 rxd_s_d;
    logic [3:0]           tick;
    logic [3:0]           bit_cnt;
    logic                 samp_a;
    logic                 samp_b;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shift_in;
    logic                 par_acc;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 brk_r;
    logic                 brk_wait;
    logic                 push_q;
    logic [WORD_W-1:0]    word_q;
    logic [WORD_W-1:0]    head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 maj;
    logic                 at_decide;
    logic                 at_end;
    logic                 start_edge;
    logic                 frame_done;
    logic                 ferr_now;
    logic                 brk_now;
    logic                 drop;

    assign maj        = majority3(samp_a, samp_b, rxd_s);
    assign at_decide  = (tick == SAMPLE_C);
    assign at_end     = (tick == BIT_END);
    assign start_edge = rxd_s_d & ~rxd_s & ~brk_wait;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk16x or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The last stop bit returns to IDLE at its decision tick, leaving half a bit
    // of margin to catch a back-to-back start edge.
    always_comb begin
        next_state = state;
        frame_done = 1'b0;
        case (state)
            IDLE:   if (start_edge) next_state = START;
            START:  begin
                if (at_decide && maj) next_state = IDLE;
                else if (at_end)      next_state = DATA;
            end
            DATA:   if (at_end && bit_cnt == LAST_BIT) begin
                next_state = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP1;
            end
            PARITY: if (at_end) next_state = STOP1;
            STOP1:  begin
                if (STOP_BITS == 2) begin
                    if (at_end) next_state = STOP2;
                end else if (at_decide) begin
                    next_state = IDLE;
                    frame_done = 1'b1;
                end
            end
            STOP2:  if (at_decide) begin
                next_state = IDLE;
                frame_done = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_in = shreg;
        if (LSB_FIRST != 0) shift_in = {maj, shreg[DATA_BITS-1:1]};
        else                shift_in = {shreg[DATA_BITS-2:0], maj};
        if (state == STOP2) begin
            ferr_now = ferr_r | ~maj;
            brk_now  = brk_r;
        end else begin
            ferr_now = ~maj;
            brk_now  = ~maj & ~|shreg;
        end
    end

    always_ff @(posedge clk16x or posedge rst) begin
        if (rst) begin
            rxd_m    <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_s_d  <= 1'b1;
            tick     <= '0;
            bit_cnt  <= '0;
            samp_a   <= 1'b1;
            samp_b   <= 1'b1;
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr_r   <= 1'b0;
            ferr_r   <= 1'b0;
            brk_r    <= 1'b0;
            brk_wait <= 1'b0;
            push_q   <= 1'b0;
            word_q   <= '0;
        end else begin
            rxd_m   <= rxd;
            rxd_s   <= rxd_m;
            rxd_s_d <= rxd_s;
            push_q  <= frame_done;
            tick    <= (state == IDLE) ? 4'd0 : tick + 4'd1;
            if (tick == SAMPLE_A) samp_a <= rxd_s;
            if (tick == SAMPLE_B) samp_b <= rxd_s;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    par_acc <= 1'b0;
                    perr_r  <= 1'b0;
                    if (rxd_s) brk_wait <= 1'b0;
                end
                DATA: begin
                    if (at_decide) begin
                        shreg   <= shift_in;
                        par_acc <= par_acc ^ maj;
                    end
                    if (at_end) bit_cnt <= bit_cnt + 4'd1;
                end
                PARITY: if (at_decide) begin
                    perr_r <= ((par_acc ^ maj) != (PARITY_MODE == PARITY_ODD));
                end
                STOP1: if (at_decide) begin
                    ferr_r <= ~maj;
                    brk_r  <= ~maj & ~|shreg;
                end
                default: ;
            endcase
            if (frame_done) begin
                word_q   <= {brk_now, ferr_now, perr_r, shreg};
                brk_wait <= brk_now;
            end
        end
    end

    uart_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk16x),
        .rst   (rst),
        .push  (push_q),
        .pop   (rd_en),
        .wdata (word_q),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A read in the same cycle makes room, so only an unread full FIFO drops.
    assign drop = push_q & fifo_full & ~rd_en;

    always_ff @(posedge clk16x or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    assign dout_valid = ~fifo_empty;
    assign dout       = dout_valid ? head[WORD_DATA_LSB +: DATA_BITS] : '0;
    assign dout_perr  = dout_valid & head[PERR_BIT];
    assign dout_ferr  = dout_valid & head[FERR_BIT];
    assign dout_brk   = dout_valid & head[BRK_BIT];

endmodule
